instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: the producer side of the decoder's `I_en` / `I_instr` interface. It holds the program counter and a synchronous-read instruction memory that is loaded through a write port. Fetched words pass through a 2-entry prefetch buffer and are presented to the decoder with a one-word-per-cycle enable. It absorbs decoder stalls without losing or duplicating words, and it redirects on taken branches.

## Interface
Parameters:
- `DEPTH`, 256: instruction memory size in 32-bit words.
- `AW`, 8: memory word-address width, equal to log2(DEPTH).
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.

Ports:
- `clk`  input  1  Single clock; everything is posedge.
- `rst`  input  1  Reset, synchronous, active-high.
- `I_stall`  input  1  Decoder cannot accept a word this cycle.
- `I_br_taken`  input  1  One-cycle redirect request.
- `I_br_target`  input  32  Redirect byte address. Bits [1:0] are ignored.
- `I_wr_en`  input  1  Program-load write strobe.
- `I_wr_addr`  input  AW  Program-load word address.
- `I_wr_data`  input  32  Program-load data.
- `O_en`  output  1  Valid word for the decoder; this is the decoder's `I_en`.
- `O_instr`  output  32  Instruction word; this is the decoder's `I_instr`.
- `O_pc`  output  32  Byte address of `O_instr`.
- `O_halt`  output  1  The fetch PC has run past the memory and the pipeline has drained.

## Operation
**Fetch PC (`F_pc`)**
- A read is issued at word index `F_pc[AW+1:2]` only when all of the following hold:
  - `F_pc[31:2] < DEPTH`;
  - no redirect is in progress;
  - buffer occupancy + in-flight reads − pop-this-cycle < 2.
- On issue, `F_pc <= F_pc + 4`.

**Memory**
- Synchronous read with 1-cycle latency.
- A read and an `I_wr_en` write to the same address in the same cycle return the old data.
- Writes are accepted in any state.
- Memory contents are not reset.

**Prefetch buffer**
- 2-entry FIFO of {instr, pc}.
- Returned read data is pushed at the end of its return cycle.
- Occupancy can never exceed 2; this is guaranteed by the issue rule.

**Decoder handshake**
- `O_en = buffer non-empty & ~I_stall & ~I_br_taken`.
- A word is consumed (popped) in exactly the cycles where `O_en = 1`.
- `O_instr` / `O_pc` show the buffer head when the buffer is non-empty, else 0.
- The head is stable while `I_stall = 1`.

**Redirect**
- When `I_br_taken = 1` in cycle t:
  - the buffer and any in-flight read are flushed at the end of t;
  - `F_pc <= {I_br_target[31:2], 2'b00}`.
- The word returned from a read issued in t or earlier is discarded.

**Halt**
- `O_halt = 1` when all of the following hold:
  - `F_pc[31:2] >= DEPTH`;
  - buffer empty;
  - no read in flight.
- Words already in the buffer drain normally before halt is raised.
- Halt is cleared by a redirect to an in-range target, or by reset.

**Priority:** `rst` > `I_br_taken` > `I_stall` > normal fetch.

## Timing
**Reset**
- While `rst = 1`: `O_en = 0`, `O_instr = 0`, `O_pc = 0`, `O_halt = 0`, buffer empty, no read in flight.
- `F_pc = RESET_PC` at the first cycle with `rst = 0`.
- Reset mid-stream discards all buffered and in-flight words.

**Startup latency**
- First cycle with `rst = 0` = c: issue in c, data returns in c+1, `O_en = 1` in c+2.

**Throughput**
- With `I_stall = 0` continuously: one word per cycle, no bubbles.

**Stall**
- `I_stall = 1` in cycle s: head held; buffer fills to 2; issue pauses.
- `I_stall` drops in cycle e: `O_en = 1` in e and again in e+1 with no gap; issue resumes so that no bubble appears.

**Redirect timing**
- `I_br_taken` in t: `O_en = 0` in t, t+1 and t+2.
- Target word appears with `O_en = 1` in t+3, provided `I_stall = 0` in t+3.
- A redirect in the same cycle as `I_stall`: the redirect acts; the stall only gates `O_en`.
- Back-to-back redirects in t and t+1: the later target wins; the target word appears in t+4.

**End of memory**
- After the word at byte address 4·(DEPTH−1) is consumed, `O_halt = 1` in the following cycle.
- `O_en` stays 0 until a redirect or reset.

## Test plan
1. Load words 0x00500093, 0x00A00113, 0x002081B3, 0x00302023 at addresses 0–3; release reset in c.
   -> `O_en = 1` in c+2..c+5; `O_pc` = 0, 4, 8, C; `O_instr` matches the loaded words in order.
2. Free-run, then assert `I_stall` for 3 cycles while `O_pc = 4`.
   -> `O_instr` held at 0x00A00113; then `O_pc` 4, 8, C on consecutive cycles; no word lost or duplicated.
3. Buffer full (stalled), pulse `I_br_taken` with target 0x22.
   -> flush; `O_en = 0` for 3 cycles; next `O_pc = 0x20` with memory word 8.
4. `DEPTH = 8`, free-run from 0.
   -> last `O_pc = 0x1C`; `O_halt = 1` the next cycle.
   -> then redirect to 0x4: `O_halt = 0` and `O_pc = 4` three cycles later.
5. `rst` asserted for 1 cycle mid-stream with 2 words buffered.
   -> all outputs 0 during reset; fetch restarts at `RESET_PC` and `O_en = 1` two cycles after release.
6. `I_stall` and `I_br_taken` both high in t with target 0x10.
   -> redirect is taken; `O_pc = 0x10` with `O_en = 1` in t+3; `I_wr_en` to the same address as an in-flight read returns old data.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: program counter, synchronous-read instruction memory
// and a 2-entry prefetch buffer driving the decoder's I_en / I_instr interface.
module instr_fetch #(
  parameter int          DEPTH    = 256,
  parameter int          AW       = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          I_stall,
  input  logic          I_br_taken,
  input  logic [31:0]   I_br_target,
  input  logic          I_wr_en,
  input  logic [AW-1:0] I_wr_addr,
  input  logic [31:0]   I_wr_data,
  output logic          O_en,
  output logic [31:0]   O_instr,
  output logic [31:0]   O_pc,
  output logic          O_halt
);

  logic [31:0] mem [DEPTH];
  logic [31:0] f_pc;
  logic        inflight;
  logic [31:0] rd_data;
  logic [31:0] rd_pc;
  logic [31:0] head_instr;
  logic [31:0] head_pc;
  logic [31:0] tail_instr;
  logic [31:0] tail_pc;
  logic [1:0]  count;
  logic        in_range;
  logic        issue;
  logic        pop;
  logic        push;
  logic        unused_target_bits;

  assign unused_target_bits = ^I_br_target[1:0];

  assign in_range = f_pc[31:2] < 30'(DEPTH);
  assign pop      = O_en;
  assign push     = inflight;

  // Words issued but not yet consumed (after this cycle's pop) stay below two,
  // so a returning read always finds room in the buffer.
  assign issue = ~rst & ~I_br_taken & in_range &
                 (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  assign O_en    = ~rst & (count != 2'd0) & ~I_stall & ~I_br_taken;
  assign O_instr = (~rst && count != 2'd0) ? head_instr : 32'h0;
  assign O_pc    = (~rst && count != 2'd0) ? head_pc : 32'h0;
  assign O_halt  = ~rst & ~in_range & (count == 2'd0) & ~inflight;

  // Write port and read port are independent; a same-address read sees old data.
  always_ff @(posedge clk) begin
    if (I_wr_en) begin
      mem[I_wr_addr] <= I_wr_data;
    end
    if (issue) begin
      rd_data <= mem[f_pc[AW+1:2]];
      rd_pc   <= f_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_pc     <= RESET_PC;
      inflight <= 1'b0;
      count    <= 2'd0;
    end else if (I_br_taken) begin
      f_pc     <= {I_br_target[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        f_pc <= f_pc + 32'd4;
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_instr <= rd_data;
            head_pc    <= rd_pc;
          end else begin
            tail_instr <= rd_data;
            tail_pc    <= rd_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_instr <= rd_data;
            head_pc    <= rd_pc;
          end else begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            tail_instr <= rd_data;
            tail_pc    <= rd_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random stimulus,
// all checked against a transaction-level model of the fetch stream.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] OLD4     = 32'h0040_0213;
  localparam logic [31:0] NEW4     = 32'hCAFE_0004;
  localparam logic [31:0] W8       = 32'h0080_0193;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, br = 1'b0, wr_en = 1'b0;
  logic [31:0] tgt = 32'h0, wr_data = 32'h0;
  logic [7:0]  wr_addr = 8'h0;
  logic        o_en, o_halt;
  logic [31:0] o_instr, o_pc;

  logic        rst_s = 1'b1, stall_s = 1'b0, br_s = 1'b0, wr_en_s = 1'b0;
  logic [31:0] tgt_s = 32'h0, wr_data_s = 32'h0;
  logic [2:0]  wr_addr_s = 3'h0;
  logic        en_s, halt_s;
  logic [31:0] instr_s, pc_s;

  instr_fetch #(.DEPTH(256), .AW(8), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .I_stall(stall), .I_br_taken(br), .I_br_target(tgt),
    .I_wr_en(wr_en), .I_wr_addr(wr_addr), .I_wr_data(wr_data),
    .O_en(o_en), .O_instr(o_instr), .O_pc(o_pc), .O_halt(o_halt)
  );

  instr_fetch #(.DEPTH(8), .AW(3), .RESET_PC(32'h0)) dut_small (
    .clk(clk), .rst(rst_s), .I_stall(stall_s), .I_br_taken(br_s), .I_br_target(tgt_s),
    .I_wr_en(wr_en_s), .I_wr_addr(wr_addr_s), .I_wr_data(wr_data_s),
    .O_en(en_s), .O_instr(instr_s), .O_pc(pc_s), .O_halt(halt_s)
  );

  // Model: every word fetched since the last restart, in order, with the cycle
  // from which it is visible to the decoder (two cycles after its issue).
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          ready;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mem_m [256];
  logic [31:0] m_pc = 32'h0;
  int          cyc = 0;
  logic        exp_en, exp_halt;
  logic [31:0] exp_instr, exp_pc;
  logic [31:0] plan_w [4];
  int          checks = 0;
  int          fails = 0;

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic we, input logic [7:0] wa, input logic [31:0] wd);
    logic head_ok;
    @(posedge clk);
    #1;
    rst = r; stall = s; br = b; tgt = t; wr_en = we; wr_addr = wa; wr_data = wd;
    head_ok   = !r && q.size() > 0 && q[0].ready <= cyc;
    exp_en    = head_ok && !s && !b;
    exp_instr = head_ok ? q[0].instr : 32'h0;
    exp_pc    = head_ok ? q[0].pc : 32'h0;
    exp_halt  = !r && (m_pc[31:2] >= 30'd256) && q.size() == 0;
    if (r) begin
      q.delete();
      m_pc = RESET_PC;
    end else if (b) begin
      q.delete();
      m_pc = {t[31:2], 2'b00};
    end else begin
      if (exp_en) void'(q.pop_front());
      if (m_pc[31:2] < 30'd256 && q.size() < 2) begin
        q.push_back('{instr: mem_m[m_pc[9:2]], pc: m_pc, ready: cyc + 2});
        m_pc = m_pc + 32'd4;
      end
    end
    if (we) mem_m[wa] = wd;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = (i < 4) ? plan_w[i] : (i == 4) ? OLD4 : (i == 8) ? W8 : $urandom;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'(i), w);
      checks++; if (o_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_en i=%0d got=%b want=0", i, o_en); end
      checks++; if (o_instr !== 32'h0) begin fails++; $display("[TB] FAIL reset_instr i=%0d got=%h want=0", i, o_instr); end
      checks++; if (o_pc !== 32'h0) begin fails++; $display("[TB] FAIL reset_pc i=%0d got=%h want=0", i, o_pc); end
      checks++; if (o_halt !== 1'b0) begin fails++; $display("[TB] FAIL reset_halt i=%0d got=%b want=0", i, o_halt); end
    end
  endtask

  task automatic test_startup();
    for (int i = 0; i < 10; i++) begin
      drive(i == 0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
      checks++; if (o_en !== exp_en) begin fails++; $display("[TB] FAIL startup_en cyc=%0d got=%b want=%b", cyc, o_en, exp_en); end
      checks++; if (o_instr !== exp_instr) begin fails++; $display("[TB] FAIL startup_instr cyc=%0d got=%h want=%h", cyc, o_instr, exp_instr); end
      checks++; if (o_pc !== exp_pc) begin fails++; $display("[TB] FAIL startup_pc cyc=%0d got=%h want=%h", cyc, o_pc, exp_pc); end
      checks++; if (o_halt !== exp_halt) begin fails++; $display("[TB] FAIL startup_halt cyc=%0d got=%b want=%b", cyc, o_halt, exp_halt); end
      if (i == 1 || i == 2) begin
        checks++; if (o_en !== 1'b0) begin fails++; $display("[TB] FAIL startup_latency i=%0d got=%b want=0", i, o_en); end
      end
      if (i >= 3 && i <= 6) begin
        checks++; if (o_en !== 1'b1 || o_pc !== 32'((i - 3) * 4) || o_instr !== plan_w[i-3]) begin
          fails++; $display("[TB] FAIL startup_word i=%0d got=%b/%h/%h want=1/%h/%h", i, o_en, o_pc, o_instr, (i - 3) * 4, plan_w[i-3]);
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 11; i++) begin
      drive(i == 0, i >= 4 && i <= 6, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
      checks++; if (o_en !== exp_en) begin fails++; $display("[TB] FAIL stall_en cyc=%0d got=%b want=%b", cyc, o_en, exp_en); end
      checks++; if (o_instr !== exp_instr) begin fails++; $display("[TB] FAIL stall_instr cyc=%0d got=%h want=%h", cyc, o_instr, exp_instr); end
      checks++; if (o_pc !== exp_pc) begin fails++; $display("[TB] FAIL stall_pc cyc=%0d got=%h want=%h", cyc, o_pc, exp_pc); end
      if (i >= 4 && i <= 6) begin
        checks++; if (o_en !== 1'b0 || o_pc !== 32'h4 || o_instr !== plan_w[1]) begin
          fails++; $display("[TB] FAIL stall_hold i=%0d got=%b/%h/%h want=0/4/%h", i, o_en, o_pc, o_instr, plan_w[1]);
        end
      end
      if (i >= 7 && i <= 9) begin
        checks++; if (o_en !== 1'b1 || o_pc !== 32'((i - 6) * 4)) begin
          fails++; $display("[TB] FAIL stall_resume i=%0d got=%b/%h want=1/%h", i, o_en, o_pc, (i - 6) * 4);
        end
      end
    end
  endtask

  task automatic test_redirect_full();
    for (int i = 0; i < 12; i++) begin
      drive(i == 0, i == 4 || i == 5, i == 6, 32'h22, 1'b0, 8'h0, 32'h0);
      checks++; if (o_en !== exp_en) begin fails++; $display("[TB] FAIL redir_en cyc=%0d got=%b want=%b", cyc, o_en, exp_en); end
      checks++; if (o_instr !== exp_instr) begin fails++; $display("[TB] FAIL redir_instr cyc=%0d got=%h want=%h", cyc, o_instr, exp_instr); end
      checks++; if (o_pc !== exp_pc) begin fails++; $display("[TB] FAIL redir_pc cyc=%0d got=%h want=%h", cyc, o_pc, exp_pc); end
      if (i >= 6 && i <= 8) begin
        checks++; if (o_en !== 1'b0) begin fails++; $display("[TB] FAIL redir_gap i=%0d got=%b want=0", i, o_en); end
      end
      if (i == 9) begin
        checks++; if (o_en !== 1'b1 || o_pc !== 32'h20 || o_instr !== W8) begin
          fails++; $display("[TB] FAIL redir_target got=%b/%h/%h want=1/20/%h", o_en, o_pc, o_instr, W8);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 12; i++) begin
      drive(i == 0 || i == 6, i == 4 || i == 5, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
      checks++; if (o_en !== exp_en) begin fails++; $display("[TB] FAIL rstmid_en cyc=%0d got=%b want=%b", cyc, o_en, exp_en); end
      checks++; if (o_pc !== exp_pc) begin fails++; $display("[TB] FAIL rstmid_pc cyc=%0d got=%h want=%h", cyc, o_pc, exp_pc); end
      checks++; if (o_halt !== exp_halt) begin fails++; $display("[TB] FAIL rstmid_halt cyc=%0d got=%b want=%b", cyc, o_halt, exp_halt); end
      if (i == 6) begin
        checks++; if (o_en !== 1'b0 || o_instr !== 32'h0 || o_pc !== 32'h0 || o_halt !== 1'b0) begin
          fails++; $display("[TB] FAIL rstmid_zero got=%b/%h/%h/%b want=0/0/0/0", o_en, o_instr, o_pc, o_halt);
        end
      end
      if (i == 7 || i == 8) begin
        checks++; if (o_en !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_flush i=%0d got=%b want=0", i, o_en); end
      end
      if (i == 9) begin
        checks++; if (o_en !== 1'b1 || o_pc !== RESET_PC || o_instr !== plan_w[0]) begin
          fails++; $display("[TB] FAIL rstmid_restart got=%b/%h/%h want=1/%h/%h", o_en, o_pc, o_instr, RESET_PC, plan_w[0]);
        end
      end
    end
  endtask

  task automatic test_stall_branch();
    for (int i = 0; i < 14; i++) begin
      drive(i == 0, i == 5, i == 5 || i == 10, 32'h10, i == 6, 8'h4, NEW4);
      checks++; if (o_en !== exp_en) begin fails++; $display("[TB] FAIL stbr_en cyc=%0d got=%b want=%b", cyc, o_en, exp_en); end
      checks++; if (o_instr !== exp_instr) begin fails++; $display("[TB] FAIL stbr_instr cyc=%0d got=%h want=%h", cyc, o_instr, exp_instr); end
      checks++; if (o_pc !== exp_pc) begin fails++; $display("[TB] FAIL stbr_pc cyc=%0d got=%h want=%h", cyc, o_pc, exp_pc); end
      if (i == 5) begin
        checks++; if (o_en !== 1'b0) begin fails++; $display("[TB] FAIL stbr_gate got=%b want=0", o_en); end
      end
      if (i == 8) begin
        checks++; if (o_en !== 1'b1 || o_pc !== 32'h10 || o_instr !== OLD4) begin
          fails++; $display("[TB] FAIL stbr_olddata got=%b/%h/%h want=1/10/%h", o_en, o_pc, o_instr, OLD4);
        end
      end
      if (i == 13) begin
        checks++; if (o_en !== 1'b1 || o_pc !== 32'h10 || o_instr !== NEW4) begin
          fails++; $display("[TB] FAIL stbr_newdata got=%b/%h/%h want=1/10/%h", o_en, o_pc, o_instr, NEW4);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      drive(i == 0, 1'b0, i == 4 || i == 5, (i == 4) ? 32'h40 : 32'h80, 1'b0, 8'h0, 32'h0);
      checks++; if (o_en !== exp_en) begin fails++; $display("[TB] FAIL b2b_en cyc=%0d got=%b want=%b", cyc, o_en, exp_en); end
      checks++; if (o_pc !== exp_pc) begin fails++; $display("[TB] FAIL b2b_pc cyc=%0d got=%h want=%h", cyc, o_pc, exp_pc); end
      if (i >= 4 && i <= 7) begin
        checks++; if (o_en !== 1'b0) begin fails++; $display("[TB] FAIL b2b_gap i=%0d got=%b want=0", i, o_en); end
      end
      if (i == 8) begin
        checks++; if (o_en !== 1'b1 || o_pc !== 32'h80 || o_instr !== mem_m[32]) begin
          fails++; $display("[TB] FAIL b2b_target got=%b/%h/%h want=1/80/%h", o_en, o_pc, o_instr, mem_m[32]);
        end
      end
    end
  endtask

  task automatic test_end_of_memory();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, i == 0 || i == 12, (i == 0) ? 32'h3F0 : 32'h4, 1'b0, 8'h0, 32'h0);
      checks++; if (o_en !== exp_en) begin fails++; $display("[TB] FAIL eom_en cyc=%0d got=%b want=%b", cyc, o_en, exp_en); end
      checks++; if (o_pc !== exp_pc) begin fails++; $display("[TB] FAIL eom_pc cyc=%0d got=%h want=%h", cyc, o_pc, exp_pc); end
      checks++; if (o_halt !== exp_halt) begin fails++; $display("[TB] FAIL eom_halt cyc=%0d got=%b want=%b", cyc, o_halt, exp_halt); end
      if (i >= 3 && i <= 6) begin
        checks++; if (o_en !== 1'b1 || o_pc !== 32'h3F0 + 32'((i - 3) * 4)) begin
          fails++; $display("[TB] FAIL eom_tail i=%0d got=%b/%h", i, o_en, o_pc);
        end
      end
      if (i >= 7 && i <= 11) begin
        checks++; if (o_halt !== 1'b1 || o_en !== 1'b0) begin fails++; $display("[TB] FAIL eom_halted i=%0d got=%b/%b want=1/0", i, o_halt, o_en); end
      end
      if (i == 13 || i == 14) begin
        checks++; if (o_halt !== 1'b0) begin fails++; $display("[TB] FAIL eom_unhalt i=%0d got=%b want=0", i, o_halt); end
      end
      if (i == 15) begin
        checks++; if (o_en !== 1'b1 || o_pc !== 32'h4) begin fails++; $display("[TB] FAIL eom_restart got=%b/%h want=1/4", o_en, o_pc); end
      end
    end
  endtask

  task automatic test_random();
    logic r, s, b, we;
    logic [31:0] t;
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99) < 2;
      s  = $urandom_range(0, 99) < 30;
      b  = $urandom_range(0, 99) < 6;
      we = $urandom_range(0, 99) < 15;
      t  = (32'($urandom_range(0, 280)) << 2) | 32'($urandom_range(0, 3));
      drive(r, s, b, t, we, 8'($urandom_range(0, 255)), $urandom);
      checks++; if (o_en !== exp_en) begin fails++; $display("[TB] FAIL rand_en cyc=%0d got=%b want=%b", cyc, o_en, exp_en); end
      checks++; if (o_instr !== exp_instr) begin fails++; $display("[TB] FAIL rand_instr cyc=%0d got=%h want=%h", cyc, o_instr, exp_instr); end
      checks++; if (o_pc !== exp_pc) begin fails++; $display("[TB] FAIL rand_pc cyc=%0d got=%h want=%h", cyc, o_pc, exp_pc); end
      checks++; if (o_halt !== exp_halt) begin fails++; $display("[TB] FAIL rand_halt cyc=%0d got=%b want=%b", cyc, o_halt, exp_halt); end
    end
  endtask

  task automatic test_small_depth();
    for (int i = 0; i < 28; i++) begin
      @(posedge clk);
      #1;
      rst_s     = (i <= 8);
      wr_en_s   = (i < 8);
      wr_addr_s = 3'(i);
      wr_data_s = 32'h1000_0000 + 32'(i);
      br_s      = (i == 23);
      tgt_s     = 32'h4;
      @(negedge clk);
      if (i <= 10) begin
        checks++; if (en_s !== 1'b0 || halt_s !== 1'b0) begin fails++; $display("[TB] FAIL small_idle i=%0d got=%b/%b want=0/0", i, en_s, halt_s); end
      end
      if (i >= 11 && i <= 18) begin
        checks++; if (en_s !== 1'b1 || pc_s !== 32'((i - 11) * 4) || instr_s !== 32'h1000_0000 + 32'(i - 11)) begin
          fails++; $display("[TB] FAIL small_word i=%0d got=%b/%h/%h want=1/%h", i, en_s, pc_s, instr_s, (i - 11) * 4);
        end
      end
      if (i >= 19 && i <= 22) begin
        checks++; if (halt_s !== 1'b1 || en_s !== 1'b0) begin fails++; $display("[TB] FAIL small_halt i=%0d got=%b/%b want=1/0", i, halt_s, en_s); end
      end
      if (i == 24 || i == 25) begin
        checks++; if (halt_s !== 1'b0 || en_s !== 1'b0) begin fails++; $display("[TB] FAIL small_redir i=%0d got=%b/%b want=0/0", i, halt_s, en_s); end
      end
      if (i == 26) begin
        checks++; if (en_s !== 1'b1 || pc_s !== 32'h4 || instr_s !== 32'h1000_0001) begin
          fails++; $display("[TB] FAIL small_restart got=%b/%h/%h want=1/4/10000001", en_s, pc_s, instr_s);
        end
      end
    end
  endtask

  initial begin
    plan_w[0] = 32'h0050_0093;
    plan_w[1] = 32'h00A0_0113;
    plan_w[2] = 32'h0020_81B3;
    plan_w[3] = 32'h0030_2023;
    test_reset();
    test_startup();
    test_stall();
    test_redirect_full();
    test_reset_midstream();
    test_stall_branch();
    test_back_to_back();
    test_end_of_memory();
    test_random();
    test_small_depth();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
